// File: rtl/multi_blink_pkg.sv
// Shared types for the multi-channel LED blinker.
//   mode_t : per-channel output mode (OFF, ON, BLINK, BURST)
//   cfg_t  : one configuration request {ch, mode, div, len}. div/len are
//            carried at CFG_W bits so the type is independent of the DBITS
//            parameter; each channel uses the low DBITS bits (DBITS <= CFG_W).
package multi_blink_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        BLINK = 2'd2,
        BURST = 2'd3
    } mode_t;

    localparam int CFG_W = 16;

    typedef struct packed {
        logic [3:0]       ch;
        mode_t            mode;
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] len;
    } cfg_t;

endpackage

// File: rtl/blink_chan.sv
// One blinker channel, advanced by the shared prescaler tick.
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   tick       prescaler tick (already suppressed by sync in the top)
//   sync       clear phase, div_cnt and pulses; configuration kept
//   apply      load cfg into this channel this cycle
//   cfg        configuration to load (mode, low DBITS of div and len)
//   led        registered output, one cycle behind mode/phase
//   done       one-cycle pulse the cycle after a BURST completes
// The channel state machine is the mode register; BURST falls back to OFF
// by itself once the requested number of on-pulses has been produced.
module blink_chan
    import multi_blink_pkg::*;
#(
    parameter int DBITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sync,
    input  logic apply,
    input  cfg_t cfg,
    output logic led,
    output logic done
);

    mode_t            mode;
    logic [DBITS-1:0] div;
    logic [DBITS-1:0] len;
    logic [DBITS-1:0] div_cnt;
    logic [DBITS-1:0] pulses;
    logic             phase;

    logic [DBITS-1:0] pulses_nxt;
    logic [DBITS-1:0] burst_len;
    logic             running;
    logic             cfg_unused;

    assign pulses_nxt = pulses + DBITS'(1);
    assign burst_len  = (len == '0) ? DBITS'(1) : len;  // len 0 means one pulse
    assign running    = (mode == BLINK) || (mode == BURST);
    // The channel index and any div/len bits above DBITS are not needed here.
    assign cfg_unused = ^{cfg.ch, cfg.div, cfg.len};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode    <= OFF;
            div     <= '0;
            len     <= '0;
            div_cnt <= '0;
            pulses  <= '0;
            phase   <= 1'b0;
            led     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            led  <= (mode == ON) || (running && phase);
            if (sync) begin
                phase   <= 1'b0;
                div_cnt <= '0;
                pulses  <= '0;
            end else if (apply) begin
                mode    <= cfg.mode;
                div     <= cfg.div[DBITS-1:0];
                len     <= cfg.len[DBITS-1:0];
                phase   <= 1'b0;
                div_cnt <= '0;
                pulses  <= '0;
            end else if (tick && running) begin
                if (div_cnt == div) begin
                    div_cnt <= '0;
                    phase   <= ~phase;
                    // A burst pulse ends on the 1->0 phase edge.
                    if (mode == BURST && phase) begin
                        pulses <= pulses_nxt;
                        if (pulses_nxt == burst_len) begin
                            mode <= OFF;
                            done <= 1'b1;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DBITS'(1);
                end
            end
        end
    end

    // While a BLINK channel's phase is high its led follows one cycle later.
    a_blink_high: assert property (@(posedge clk) disable iff (rst)
        (mode == BLINK && phase) |=> led);
    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        done |=> !done);

endmodule

// File: rtl/multi_blink.sv
// Multi-channel LED blinker: NCH channels share one free-running prescaler.
// Ports:
//   clk, rst    clock / asynchronous active-high reset
//   sync        restart prescaler and all channel counters in phase
//   cfg_valid   config request; cfg_ready high when the pending slot is free
//   cfg_ch      target channel, cfg_mode/cfg_div/cfg_len its new settings
//   led[NCH]    registered channel outputs
//   flg         one-cycle pulse the cycle after pre_cnt == 0
//   done[NCH]   one-cycle pulse per channel when a BURST completes
//   cfg_err     one-cycle pulse when a config for cfg_ch >= NCH is dropped
// Handshake: a config transfers on a rising edge where cfg_valid && cfg_ready.
// It sits in a single pending slot (cfg_ready low) until the next tick, where
// it is applied; cfg_ready returns high the cycle after that tick. A transfer
// in a tick cycle therefore waits for the following tick.
module multi_blink
    import multi_blink_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CBITS = 28,
    parameter int DBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [DBITS-1:0] cfg_div,
    input  logic [DBITS-1:0] cfg_len,
    output logic [NCH-1:0]   led,
    output logic             flg,
    output logic [NCH-1:0]   done,
    output logic             cfg_err
);

    logic [CBITS-1:0] pre_cnt;
    cfg_t             pend;
    logic             tick;
    logic             apply_now;
    logic             ch_bad;

    // sync outranks the tick: the prescaler restarts instead of advancing
    // channels or applying the pending slot.
    assign tick      = (pre_cnt == '0) && !sync;
    assign apply_now = tick && !cfg_ready;
    assign ch_bad    = int'(pend.ch) >= NCH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt   <= '0;
            flg       <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
            pend      <= '0;
        end else begin
            flg     <= (pre_cnt == '0);
            cfg_err <= apply_now && ch_bad;
            if (sync) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + CBITS'(1);
            end
            if (apply_now) begin
                cfg_ready <= 1'b1;
            end else if (cfg_valid && cfg_ready) begin
                pend      <= '{ch:   cfg_ch,
                               mode: mode_t'(cfg_mode),
                               div:  CFG_W'(cfg_div),
                               len:  CFG_W'(cfg_len)};
                cfg_ready <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        blink_chan #(.DBITS(DBITS)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .sync  (sync),
            .apply (apply_now && (pend.ch == 4'(i))),
            .cfg   (pend),
            .led   (led[i]),
            .done  (done[i])
        );
    end

    // Cycles the slot has been occupied; restarted by sync, which may
    // legitimately postpone the apply tick.
    logic [CBITS+1:0] stall_cnt;
    localparam longint STALL_MAX = (longint'(1) << CBITS) + 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cfg_ready || sync) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + (CBITS+2)'(1);
        end
    end

    a_ready_bound: assert property (@(posedge clk) disable iff (rst)
        longint'(stall_cnt) <= STALL_MAX);
    a_err_pulse: assert property (@(posedge clk) disable iff (rst)
        cfg_err |=> !cfg_err);

endmodule

// File: tb/tb_multi_blink.sv
// Bench for multi_blink with NCH=4, CBITS=3 (tick every 8 cycles), DBITS=4.
// Cycle k is the interval after the k-th rising edge following reset
// release; inputs change and outputs are sampled on falling edges.
// Expected output events {cycle, led, done, cfg_err} are queued as each
// stimulus is issued; the monitor pops one whenever led changes or a
// done/cfg_err pulse appears.
module tb_multi_blink;
    localparam int NCH   = 4;
    localparam int CBITS = 3;
    localparam int DBITS = 4;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_BURST = 2'd3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sync = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [3:0]       cfg_ch = '0;
    logic [1:0]       cfg_mode = '0;
    logic [DBITS-1:0] cfg_div = '0;
    logic [DBITS-1:0] cfg_len = '0;
    logic [NCH-1:0]   led;
    logic             flg;
    logic [NCH-1:0]   done;
    logic             cfg_err;

    int total = 0;
    int bad   = 0;
    int cyc;

    logic [24:0] exp_q[$];

    multi_blink #(.NCH(NCH), .CBITS(CBITS), .DBITS(DBITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_div   (cfg_div),
        .cfg_len   (cfg_len),
        .led       (led),
        .flg       (flg),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got time=%0t required finish earlier", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: cyc=%0d got=%0h required=%0h", name, cyc, got, want);
        end
    endtask

    task automatic push(input int c, input logic [3:0] l, input logic [3:0] d, input logic e);
        exp_q.push_back({16'(c), l, d, e});
    endtask

    // Called on a falling edge; returns on the falling edge after transfer.
    task automatic send_cfg(input logic [3:0] ch, input logic [1:0] mode,
                            input logic [3:0] div, input logic [3:0] len);
        int n;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_div   = div;
        cfg_len   = len;
        n = 0;
        while (!cfg_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n == 40) begin
            total++;
            bad++;
            $display("FAIL cfg_accept: ch=%0d got cfg_ready=0 for 40 cycles required 1", ch);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [NCH-1:0] prev_led;
        logic [24:0]    got;
        logic [24:0]    want;
        prev_led = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_led = led;
            end else begin
                if (led != prev_led || done != '0 || cfg_err) begin
                    got = {16'(cyc), led, done, cfg_err};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_event: got cyc=%0d led=%b done=%b err=%b required none",
                                 cyc, led, done, cfg_err);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            bad++;
                            $display("FAIL event: got cyc=%0d led=%b done=%b err=%b required cyc=%0d led=%b done=%b err=%b",
                                     got[24:9], got[8:5], got[4:1], got[0],
                                     want[24:9], want[8:5], want[4:1], want[0]);
                        end
                    end
                end
                prev_led = led;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_flg", 32'(flg), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;

        // flg pulses at cycles 1, 9, 17.
        for (int k = 0; k < 18; k++) begin
            wait_until(k);
            check("flg_period", 32'(flg), 32'((k % 8) == 1));
        end

        // ch1 BLINK div=1: transfer end of 18, applied at tick 24,
        // phase toggles at ticks 40, 56, 72, 88; led lags phase by one.
        wait_until(18);
        push(42, 4'b0010, 4'b0000, 1'b0);
        push(58, 4'b0000, 4'b0000, 1'b0);
        push(74, 4'b0010, 4'b0000, 1'b0);
        push(90, 4'b0000, 4'b0000, 1'b0);
        send_cfg(4'd1, M_BLINK, 4'd1, 4'd0);
        check("blink_ready_busy", 32'(cfg_ready), 32'd0);
        wait_until(24);
        check("blink_ready_at_tick", 32'(cfg_ready), 32'd0);
        wait_until(25);
        check("blink_ready_free", 32'(cfg_ready), 32'd1);
        wait_until(91);
        send_cfg(4'd1, M_OFF, 4'd0, 4'd0);  // applied at tick 96, led stays 0

        // ch2 BURST div=0 len=3: applied at 104, three 8-cycle highs,
        // done the cycle after the final phase fall at tick 152.
        wait_until(97);
        push(114, 4'b0100, 4'b0000, 1'b0);
        push(122, 4'b0000, 4'b0000, 1'b0);
        push(130, 4'b0100, 4'b0000, 1'b0);
        push(138, 4'b0000, 4'b0000, 1'b0);
        push(146, 4'b0100, 4'b0000, 1'b0);
        push(153, 4'b0100, 4'b0100, 1'b0);
        push(154, 4'b0000, 4'b0000, 1'b0);
        send_cfg(4'd2, M_BURST, 4'd0, 4'd3);
        wait_until(104);
        check("burst_ready_busy", 32'(cfg_ready), 32'd0);
        wait_until(105);
        check("burst_ready_free", 32'(cfg_ready), 32'd1);

        // Transfer in tick cycle 160 (ch=5, dropped) waits for tick 168;
        // the queued second request (ch3 ON) stalls until 169, applies at 176.
        wait_until(160);
        push(169, 4'b0000, 4'b0000, 1'b1);
        push(178, 4'b1000, 4'b0000, 1'b0);
        fork
            begin
                send_cfg(4'd5, M_ON, 4'd0, 4'd0);
                send_cfg(4'd3, M_ON, 4'd0, 4'd0);
            end
            begin
                wait_until(161);
                check("tickxfer_ready_161", 32'(cfg_ready), 32'd0);
                wait_until(168);
                check("tickxfer_ready_168", 32'(cfg_ready), 32'd0);
                wait_until(169);
                check("tickxfer_ready_169", 32'(cfg_ready), 32'd1);
                wait_until(170);
                check("stall_ready_170", 32'(cfg_ready), 32'd0);
                wait_until(177);
                check("stall_ready_177", 32'(cfg_ready), 32'd1);
            end
        join

        // ch0 BLINK div=2 applied at 184, ch3 BLINK div=2 applied at 192;
        // sync in tick cycle 216 restarts both: ticks at 217+8k, joint
        // toggles at 233 and 257.
        wait_until(177);
        push(194, 4'b0000, 4'b0000, 1'b0);
        push(210, 4'b0001, 4'b0000, 1'b0);
        push(218, 4'b0000, 4'b0000, 1'b0);
        push(235, 4'b1001, 4'b0000, 1'b0);
        push(259, 4'b0000, 4'b0000, 1'b0);
        send_cfg(4'd0, M_BLINK, 4'd2, 4'd0);
        wait_until(185);
        send_cfg(4'd3, M_BLINK, 4'd2, 4'd0);
        wait_until(216);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        wait_until(218);
        check("sync_flg_218", 32'(flg), 32'd1);
        wait_until(225);
        check("sync_flg_225", 32'(flg), 32'd0);
        wait_until(226);
        check("sync_flg_226", 32'(flg), 32'd1);

        // ch2 BURST div=0 len=2 applied at tick 265, reset mid-burst at 294.
        wait_until(264);
        push(275, 4'b0100, 4'b0000, 1'b0);
        push(283, 4'b1001, 4'b0000, 1'b0);
        push(291, 4'b1101, 4'b0000, 1'b0);
        send_cfg(4'd2, M_BURST, 4'd0, 4'd2);
        wait_until(294);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        // All channels OFF now: the monitor must see no event at all.
        wait_until(40);
        check("postrst_led", 32'(led), 32'd0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_events: got %0d unseen required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
